// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate stage: FSM states, product width,
// and the parameter legality check used at elaboration.
package mac_pkg;

    localparam int unsigned PROD_W = 16;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic bit params_ok(input int unsigned n_terms, input int unsigned acc_w);
        return (acc_w >= PROD_W) && (acc_w <= 32) && (n_terms >= 1) && (n_terms <= 255);
    endfunction

endpackage

// File: rtl/Eight_Bit_Multiplier.sv
// Unsigned 8x8 combinational multiplier feeding the accumulator's operand register.
module Eight_Bit_Multiplier (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] P
);

    assign P = A * B;

endmodule

// File: rtl/mac_accumulator.sv
// Sums N_TERMS unsigned 8x8 products per result behind valid/ready handshakes;
// a registered product stage means the last term is added one cycle after its accept.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum,
    output logic             overflow
);

    if (!params_ok(N_TERMS, ACC_W)) begin : g_param_check
        $error("mac_accumulator: illegal N_TERMS=%0d / ACC_W=%0d", N_TERMS, ACC_W);
    end

    localparam logic [7:0] LAST_TERM = 8'(N_TERMS - 1);

    state_t              state;
    logic [PROD_W-1:0]   prod_w;
    logic [PROD_W-1:0]   prod_q;
    logic                prod_v;
    logic [7:0]          term_cnt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W:0]      acc_sum;
    logic                accept;

    Eight_Bit_Multiplier u_mult (
        .A (a),
        .B (b),
        .P (prod_w)
    );

    assign accept = in_valid && in_ready;
    assign sum    = acc;

    always_comb begin
        acc_sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            overflow  <= 1'b0;
            term_cnt  <= '0;
            prod_v    <= 1'b0;
            prod_q    <= '0;
        end else if (clear) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            overflow  <= 1'b0;
            term_cnt  <= '0;
            prod_v    <= 1'b0;
        end else begin
            prod_v <= accept;
            if (accept) begin
                prod_q   <= prod_w;
                term_cnt <= term_cnt + 8'd1;
            end
            if (prod_v) begin
                acc <= acc_sum[ACC_W-1:0];
                if (acc_sum[ACC_W]) begin
                    overflow <= 1'b1;
                end
            end

            // Assignments below deliberately override the datapath updates above.
            case (state)
                ACCUM: begin
                    if (accept && (term_cnt == LAST_TERM)) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        state     <= ACCUM;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        acc       <= '0;
                        overflow  <= 1'b0;
                        term_cnt  <= '0;
                        prod_v    <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    acc       <= '0;
                    overflow  <= 1'b0;
                    term_cnt  <= '0;
                    prod_v    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: directed vector table and corner sequences, then random
// traffic on an N=4/24-bit and an N=2/16-bit instance checked against a dot-product model.
module tb_mac_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clear, in_valid, out_ready;
    logic [7:0] a, b;

    logic        ir4, ov4, of4;
    logic [23:0] s4;
    logic        ir2, ov2, of2;
    logic [15:0] s2;

    mac_accumulator #(.N_TERMS(4), .ACC_W(24)) dut4 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir4),
        .a(a), .b(b), .out_valid(ov4), .out_ready(out_ready), .sum(s4), .overflow(of4)
    );

    mac_accumulator #(.N_TERMS(2), .ACC_W(16)) dut2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir2),
        .a(a), .b(b), .out_valid(ov2), .out_ready(out_ready), .sum(s2), .overflow(of2)
    );

    // Index 0 is the N=4 instance, index 1 the N=2 instance.
    int          sel;
    logic        irs [2];
    logic        ovs [2];
    logic        ofs [2];
    logic [31:0] sms [2];

    always_comb begin
        irs[0] = ir4; ovs[0] = ov4; ofs[0] = of4; sms[0] = {8'h00, s4};
        irs[1] = ir2; ovs[1] = ov2; ofs[1] = of2; sms[1] = {16'h0000, s2};
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Feed n pairs (optional bubble after pair i when gap[i]), check drain latency,
    // result, hold under backpressure, then the handshake and return to ACCUM.
    task automatic do_result(input int n, input logic [31:0] av, input logic [31:0] bv,
                             input logic [3:0] gap, input int hold,
                             input logic [31:0] es, input logic eo, input string tag);
        logic [3:0][7:0] pa, pb;
        pa = av;
        pb = bv;
        for (int i = 0; i < n; i++) begin
            a = pa[i]; b = pb[i]; in_valid = 1'b1;
            chk({tag, "_in_ready"}, irs[sel], 1);
            tick;
            if (gap[i] && i < n - 1) begin
                in_valid = 1'b0; a = 8'hFF; b = 8'hFF;
                chk({tag, "_bubble_in_ready"}, irs[sel], 1);
                chk({tag, "_bubble_out_valid"}, ovs[sel], 0);
                tick;
            end
        end
        in_valid = 1'b0;
        chk({tag, "_drain_in_ready"}, irs[sel], 0);
        chk({tag, "_drain_out_valid"}, ovs[sel], 0);
        tick;
        chk({tag, "_out_valid"}, ovs[sel], 1);
        chk({tag, "_sum"}, sms[sel], es);
        chk({tag, "_overflow"}, ofs[sel], eo);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
            tick;
            chk({tag, "_hold_out_valid"}, ovs[sel], 1);
            chk({tag, "_hold_sum"}, sms[sel], es);
            chk({tag, "_hold_overflow"}, ofs[sel], eo);
            chk({tag, "_hold_in_ready"}, irs[sel], 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, "_post_in_ready"}, irs[sel], 1);
        chk({tag, "_post_out_valid"}, ovs[sel], 0);
        chk({tag, "_post_sum"}, sms[sel], 0);
    endtask

    typedef struct {
        logic [31:0] av;
        logic [31:0] bv;
        logic [3:0]  gap;
        logic [31:0] es;
        logic        eo;
    } vec_t;

    vec_t tbl [4];

    // Transaction-level reference: a result is the plain integer dot product of the
    // accepted pairs; it is shown 2 cycles after the last accept, reduced mod 2^W,
    // and overflow means the true total reached 2^W.
    int     ph  [2];
    int     cnt [2];
    longint tot [2];
    int     nt  [2] = '{4, 2};
    int     aw  [2] = '{24, 16};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0].av = 32'hAAAAAAAA; tbl[0].bv = 32'hCCCCCCCC; tbl[0].gap = 4'b0000;
        tbl[0].es = 32'h00021DE0; tbl[0].eo = 1'b0;
        tbl[1].av = 32'hFFFFFFFF; tbl[1].bv = 32'hFFFFFFFF; tbl[1].gap = 4'b0000;
        tbl[1].es = 32'h0003F804; tbl[1].eo = 1'b0;
        tbl[2].av = 32'h10000201; tbl[2].bv = 32'h10000301; tbl[2].gap = 4'b0101;
        tbl[2].es = 32'h00000107; tbl[2].eo = 1'b0;
        tbl[3].av = 32'h0700FF80; tbl[3].bv = 32'h09FF0102; tbl[3].gap = 4'b0010;
        tbl[3].es = 32'h0000023E; tbl[3].eo = 1'b0;

        sel = 0;
        do_reset;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset%0d_in_ready", i), irs[i], 1);
            chk($sformatf("reset%0d_out_valid", i), ovs[i], 0);
            chk($sformatf("reset%0d_sum", i), sms[i], 0);
            chk($sformatf("reset%0d_overflow", i), ofs[i], 0);
        end

        for (int i = 0; i < 4; i++) begin
            do_result(4, tbl[i].av, tbl[i].bv, tbl[i].gap, 0, tbl[i].es, tbl[i].eo,
                      $sformatf("vec%0d", i));
        end

        do_result(4, 32'hAAAAAAAA, 32'hCCCCCCCC, 4'b0111, 5, 32'h00021DE0, 1'b0, "bp");

        sel = 1;
        do_reset;
        do_result(2, 32'h0000FFFF, 32'h0000FFFF, 4'b0000, 0, 32'h0000FC02, 1'b1, "ovf");
        do_result(2, 32'h00000201, 32'h00000301, 4'b0000, 0, 32'h00000007, 1'b0, "ovf_next");

        sel = 0;
        do_reset;
        a = 8'h10; b = 8'h10; in_valid = 1'b1;
        tick;
        tick;
        clear = 1'b1;
        tick;
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_in_ready", irs[0], 1);
        chk("clr_out_valid", ovs[0], 0);
        chk("clr_sum", sms[0], 0);
        tick;
        chk("clr_sum_after", sms[0], 0);
        do_result(4, 32'h01010101, 32'h01010101, 4'b0000, 0, 32'h00000004, 1'b0, "clr");

        do_reset;
        a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        in_valid = 1'b0;
        chk("rstmid_drain_out_valid", ovs[0], 0);
        rst = 1'b1;
        #1;
        chk("rstmid_out_valid", ovs[0], 0);
        chk("rstmid_sum", sms[0], 0);
        chk("rstmid_in_ready", irs[0], 1);
        chk("rstmid_overflow", ofs[0], 0);
        #2;
        rst = 1'b0;
        tick;
        do_result(4, tbl[0].av, tbl[0].bv, 4'b0000, 0, tbl[0].es, 1'b0, "rstmid_after");

        do_reset;
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; cnt[i] = 0; tot[i] = 0;
        end
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rnd%0d_out_valid", nt[i]), ovs[i], (ph[i] == 2) ? 1 : 0);
                chk($sformatf("rnd%0d_in_ready", nt[i]), irs[i], (ph[i] == 0) ? 1 : 0);
                if (ph[i] == 2) begin
                    chk($sformatf("rnd%0d_sum", nt[i]), sms[i],
                        32'(tot[i] & ((64'd1 << aw[i]) - 1)));
                    chk($sformatf("rnd%0d_overflow", nt[i]), ofs[i],
                        (tot[i] >= (64'd1 << aw[i])) ? 1 : 0);
                end
            end
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = 1'($urandom_range(0, 1));
            clear     = ($urandom_range(0, 39) == 0);
            a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            for (int i = 0; i < 2; i++) begin
                if (clear) begin
                    ph[i] = 0; cnt[i] = 0; tot[i] = 0;
                end else if (ph[i] == 0) begin
                    if (in_valid) begin
                        tot[i] += longint'(a) * longint'(b);
                        cnt[i]++;
                        if (cnt[i] == nt[i]) ph[i] = 1;
                    end
                end else if (ph[i] == 1) begin
                    ph[i] = 2;
                end else if (out_ready) begin
                    ph[i] = 0; cnt[i] = 0; tot[i] = 0;
                end
            end
            tick;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
